// File: rtl/branch_predict_unit.sv
// Fetch-side branch predictor: direct-mapped table of 2-bit counters and targets,
// with EX-stage mispredict detection and redirect. Define BPU_STATS_EN for event counters.
module branch_predict_unit #(
   parameter int PC_W  = 10,
   parameter int IDX_W = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [PC_W-1:0] if_pc,
   output logic            pred_taken,
   output logic [PC_W-1:0] pred_next_pc,
   input  logic            upd_valid,
   input  logic [PC_W-1:0] upd_pc,
   input  logic            upd_taken,
   input  logic [PC_W-1:0] upd_target,
   input  logic            upd_pred_taken,
   input  logic [PC_W-1:0] upd_pred_target,
   output logic            flush,
   output logic [PC_W-1:0] redirect_pc
`ifdef BPU_STATS_EN
   ,
   output logic [15:0]     stat_branches,
   output logic [15:0]     stat_mispredicts
`endif
);

   localparam int ENTRIES = 1 << IDX_W;
   localparam int TAG_W   = PC_W - IDX_W;

   logic             valid  [ENTRIES];
   logic [TAG_W-1:0] tag    [ENTRIES];
   logic [PC_W-1:0]  target [ENTRIES];
   logic [1:0]       ctr    [ENTRIES];

   logic [IDX_W-1:0] lk_idx;
   logic [IDX_W-1:0] up_idx;
   logic             lk_hit;
   logic             up_hit;
   logic             mispredict;

   // Gating with rst keeps outputs quiet while the table is held in reset.
   assign lk_idx       = if_pc[IDX_W-1:0];
   assign lk_hit       = rst & valid[lk_idx] & (tag[lk_idx] == if_pc[PC_W-1:IDX_W]);
   assign pred_taken   = lk_hit & ctr[lk_idx][1];
   assign pred_next_pc = pred_taken ? target[lk_idx] : if_pc + PC_W'(1);

   assign mispredict  = (upd_taken != upd_pred_taken) |
                        (upd_taken & (upd_target != upd_pred_target));
   assign flush       = rst & upd_valid & mispredict;
   assign redirect_pc = !flush    ? '0 :
                        upd_taken ? upd_target : upd_pc + PC_W'(1);

   assign up_idx = upd_pc[IDX_W-1:0];
   assign up_hit = valid[up_idx] & (tag[up_idx] == upd_pc[PC_W-1:IDX_W]);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid[i]  <= 1'b0;
            tag[i]    <= '0;
            target[i] <= '0;
            ctr[i]    <= 2'b01;
         end
      end else if (upd_valid) begin
         if (up_hit) begin
            if (upd_taken) begin
               if (ctr[up_idx] != 2'b11) ctr[up_idx] <= ctr[up_idx] + 2'b01;
               target[up_idx] <= upd_target;
            end else if (ctr[up_idx] != 2'b00) begin
               ctr[up_idx] <= ctr[up_idx] - 2'b01;
            end
         end else if (upd_taken) begin
            // Taken miss allocates, evicting any aliasing entry; starts weakly taken.
            valid[up_idx]  <= 1'b1;
            tag[up_idx]    <= upd_pc[PC_W-1:IDX_W];
            target[up_idx] <= upd_target;
            ctr[up_idx]    <= 2'b10;
         end
      end
   end

`ifdef BPU_STATS_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stat_branches    <= '0;
         stat_mispredicts <= '0;
      end else begin
         if (upd_valid && stat_branches != 16'hFFFF) stat_branches <= stat_branches + 16'd1;
         if (flush && stat_mispredicts != 16'hFFFF) stat_mispredicts <= stat_mispredicts + 16'd1;
      end
   end
`else
   // No statistics hardware in this build.
`endif

endmodule
